// File: rtl/pm_scan_sequencer_if.sv
// ADC mux/conversion handshake and threshold-programming bus of the power-monitor scan sequencer.
// The master side is the sequencer; the slave side is the ADC front end plus the register host.
interface pm_scan_sequencer_if #(
    parameter int AdcWidth = 12
);
    logic                adc_soc;
    logic [4:0]          mux_sel;
    logic                adc_eoc;
    logic [AdcWidth-1:0] adc_data;
    logic                thr_wr;
    logic [4:0]          thr_addr;
    logic [1:0]          thr_sel;
    logic [AdcWidth-1:0] thr_data;

    modport master (
        output adc_soc, mux_sel,
        input  adc_eoc, adc_data, thr_wr, thr_addr, thr_sel, thr_data
    );

    modport slave (
        input  adc_soc, mux_sel,
        output adc_eoc, adc_data, thr_wr, thr_addr, thr_sel, thr_data
    );
endinterface

// File: rtl/pm_scan_sequencer.sv
// Round-robin power-monitor scan: settle the ADC mux, start a conversion, capture the result
// and check it against per-rail fault/warn windows, raising pgood, sticky faults and eoc.
module pm_scan_sequencer #(
    parameter int NumConverters = 8,
    parameter int AdcWidth      = 12,
    parameter int SettleCycles  = 4,
    parameter int TimeoutCycles = 255
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       clear_faults,
    pm_scan_sequencer_if.master        bus,
    output logic                       busy,
    output logic [31:0]                pgood_bus,
    output logic [31:0]                fault_status,
    output logic                       fault,
    output logic                       warn,
    output logic                       eoc
);
    typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, COMPARE} state_t;

    localparam logic [4:0]          LastRail    = 5'(NumConverters - 1);
    localparam logic [5:0]          RailCount   = 6'(NumConverters);
    localparam logic [7:0]          SettleLast  = 8'(SettleCycles - 1);
    localparam logic [15:0]         TimeoutLast = 16'(TimeoutCycles - 1);
    localparam logic [AdcWidth-1:0] AllOnes     = '1;

    state_t              state;
    logic [4:0]          rail_ptr;
    logic [7:0]          settle_cnt;
    logic [15:0]         timeout_cnt;
    logic                timed_out;
    logic [AdcWidth-1:0] sample;
    logic [31:0]         warn_bits;
    logic                rail_fault;
    logic                rail_warn;
    logic [31:0]         rail_onehot;

    // Entries at or above NumConverters are never written and stay at their reset values.
    logic [AdcWidth-1:0] ov_fault [32];
    logic [AdcWidth-1:0] uv_fault [32];
    logic [AdcWidth-1:0] ov_warn  [32];
    logic [AdcWidth-1:0] uv_warn  [32];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                ov_fault[i] <= AllOnes;
                uv_fault[i] <= '0;
                ov_warn[i]  <= AllOnes;
                uv_warn[i]  <= '0;
            end
        end else if (bus.thr_wr && ({1'b0, bus.thr_addr} < RailCount)) begin
            case (bus.thr_sel)
                2'd0:    ov_fault[bus.thr_addr] <= bus.thr_data;
                2'd1:    uv_fault[bus.thr_addr] <= bus.thr_data;
                2'd2:    ov_warn[bus.thr_addr]  <= bus.thr_data;
                default: uv_warn[bus.thr_addr]  <= bus.thr_data;
            endcase
        end
    end

    // A timed-out conversion is a fault but never a warning.
    always_comb begin
        rail_onehot = 32'd1 << rail_ptr;
        rail_fault  = 1'b1;
        rail_warn   = 1'b0;
        if (!timed_out) begin
            rail_fault = (sample > ov_fault[rail_ptr]) || (sample < uv_fault[rail_ptr]);
            rail_warn  = (sample > ov_warn[rail_ptr])  || (sample < uv_warn[rail_ptr]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            rail_ptr     <= '0;
            settle_cnt   <= '0;
            timeout_cnt  <= '0;
            timed_out    <= 1'b0;
            sample       <= '0;
            bus.adc_soc  <= 1'b0;
            eoc          <= 1'b0;
            pgood_bus    <= '0;
            fault_status <= '0;
            warn_bits    <= '0;
        end else begin
            eoc <= 1'b0;
            // A fault found in the same cycle as a clear survives the clear.
            if (clear_faults) begin
                fault_status <= (state == COMPARE && rail_fault) ? rail_onehot : 32'd0;
            end else if (state == COMPARE && rail_fault) begin
                fault_status <= fault_status | rail_onehot;
            end

            case (state)
                IDLE: begin
                    settle_cnt <= '0;
                    if (enable) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SettleLast) begin
                        state       <= START;
                        bus.adc_soc <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                START: begin
                    bus.adc_soc <= 1'b0;
                    timeout_cnt <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (bus.adc_eoc) begin
                        sample    <= bus.adc_data;
                        timed_out <= 1'b0;
                        state     <= COMPARE;
                    end else if (timeout_cnt == TimeoutLast) begin
                        timed_out <= 1'b1;
                        state     <= COMPARE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end
                COMPARE: begin
                    pgood_bus[rail_ptr] <= !rail_fault;
                    warn_bits[rail_ptr] <= rail_warn;
                    settle_cnt          <= '0;
                    if (rail_ptr == LastRail) begin
                        rail_ptr <= '0;
                        eoc      <= 1'b1;
                    end else begin
                        rail_ptr <= rail_ptr + 5'd1;
                    end
                    state <= enable ? SETTLE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mux_sel = rail_ptr;
    assign busy        = (state != IDLE);
    assign fault       = |fault_status;
    assign warn        = |warn_bits;
endmodule
